// File: rtl/alu_seq_pkg.sv
// Shared constants, FSM state type and flag layout for the ALU sequencer.
// Multiply support is enabled with the ALU_SEQ_MUL_EN macro.
package alu_seq_pkg;

  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [3:0] CMD_MUL    = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // rsp_flags layout is {C,V,N,Z}
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                             input logic n, input logic z);
    logic [3:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_acc.sv
// Shift-add multiply accumulator: {acc_hi,acc_lo} with W-step iteration counter.
// One iteration per step cycle; done pulses on the step that completes iteration W.
module alu_seq_acc #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [W-1:0]   load_b,
  input  logic           step,
  input  logic [W-1:0]   sum,
  input  logic           sum_c,
  output logic [W-1:0]   acc_hi,
  output logic           acc_lsb,
  output logic [2*W-1:0] nxt,
  output logic           done
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  acc_lo;
  logic [CW-1:0] cnt;

  // The ALU sum lands in the high half while the multiplier shifts out of the low half.
  assign nxt     = {sum_c, sum, acc_lo[W-1:1]};
  assign acc_lsb = acc_lo[0];
  assign done    = step && (cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc_hi <= '0;
      acc_lo <= load_b;
      cnt    <= '0;
    end else if (step) begin
      {acc_hi, acc_lo} <= nxt;
      cnt              <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences single ALU ops (2 cycles to response) and, with ALU_SEQ_MUL_EN, W-step MULs (W+1 cycles).
// One command in flight: cmd_ready only in IDLE; response held until rsp_ready.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [3:0]     cmd_op,
  input  logic [W-1:0]   cmd_a,
  input  logic [W-1:0]   cmd_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_y,
  output logic [3:0]     rsp_flags,
  output logic           rsp_err,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [2:0]     alu_op,
  input  logic [W-1:0]   alu_y,
  input  logic           alu_c,
  input  logic           alu_v,
  input  logic           alu_n,
  input  logic           alu_z
);

  state_t         state, state_nxt;
  logic [2:0]     op_r;
  logic [W-1:0]   a_r, b_r;
  logic [2*W-1:0] y_r;
  logic [3:0]     flags_r;
  logic           err_r;
  logic           cmd_fire, cmd_mul, cmd_bad;

  assign cmd_fire = cmd_valid && (state == ST_IDLE);

`ifdef ALU_SEQ_MUL_EN
  logic [W-1:0]   acc_hi;
  logic           acc_lsb;
  logic [2*W-1:0] mul_nxt;
  logic           mul_done;

  assign cmd_mul = (cmd_op == CMD_MUL);

  alu_seq_acc #(.W(W)) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cmd_fire && cmd_mul),
    .load_b (cmd_b),
    .step   (state == ST_MUL),
    .sum    (alu_y),
    .sum_c  (alu_c),
    .acc_hi (acc_hi),
    .acc_lsb(acc_lsb),
    .nxt    (mul_nxt),
    .done   (mul_done)
  );
`else
  assign cmd_mul = 1'b0;
`endif

  assign cmd_bad = cmd_op[3] && !cmd_mul;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (!cmd_op[3])   state_nxt = ST_EXEC;
          else if (cmd_mul) state_nxt = ST_MUL;
          else              state_nxt = ST_RESP;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
`ifdef ALU_SEQ_MUL_EN
      ST_MUL:  if (mul_done) state_nxt = ST_RESP;
`endif
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The external ALU only sees live operands while a computation is running.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = ALU_OP_ADD;
    case (state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_EXEC: begin
        alu_a  = a_r;
        alu_b  = b_r;
        alu_op = op_r;
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        alu_a  = acc_hi;
        alu_b  = acc_lsb ? a_r : '0;
        alu_op = ALU_OP_ADD;
      end
`endif
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      y_r     <= '0;
      flags_r <= '0;
      err_r   <= 1'b0;
    end else begin
      if (cmd_fire) begin
        op_r <= cmd_op[2:0];
        a_r  <= cmd_a;
        b_r  <= cmd_b;
      end
      if (cmd_fire && cmd_bad) begin
        y_r     <= '0;
        flags_r <= '0;
        err_r   <= 1'b1;
      end else if (state == ST_EXEC) begin
        y_r     <= {{W{1'b0}}, alu_y};
        flags_r <= pack_flags(alu_c, alu_v, alu_n, alu_z);
        err_r   <= 1'b0;
      end
`ifdef ALU_SEQ_MUL_EN
      // Capture the product as it is formed on the final iteration.
      else if (mul_done) begin
        y_r     <= mul_nxt;
        flags_r <= pack_flags(1'b0, 1'b0, mul_nxt[2*W-1], (mul_nxt == '0));
        err_r   <= 1'b0;
      end
`endif
    end
  end

  assign rsp_y     = y_r;
  assign rsp_flags = flags_r;
  assign rsp_err   = err_r;

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have one parameter: W, default 8, datapath width (the 8-bit ALU width; other values are unsupported).
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- cmd_valid, in, 1: command present.
- cmd_ready, out, 1: command accepted when high with cmd_valid.
- cmd_op, in, 4: bit3=0 selects single ALU op cmd_op[2:0]; 4'b1000 selects MUL.
- cmd_a / cmd_b, in, W each: operands.
- rsp_valid, out, 1: response present.
- rsp_ready, in, 1: response consumed when high with rsp_valid.
- rsp_y, out, 2W: result.
- rsp_flags, out, 4: {C,V,N,Z}.
- rsp_err, out, 1: illegal command.
- alu_a / alu_b, out, W each: ALU operands.
- alu_op, out, 3: ALU opcode.
- alu_y, in, W: ALU result (combinational).
- alu_c / alu_v / alu_n / alu_z, in, 1 each: ALU flags.
REQ-003 Clocking and reset SHALL be exactly one clock (clk) and an asynchronous, active-low reset (rst_n).

Function
REQ-004 The FSM SHALL have states IDLE, EXEC, MUL, RESP.
REQ-005 cmd_ready SHALL be 1 only in IDLE; a handshake registers cmd_op/cmd_a/cmd_b.
REQ-006 A single op (cmd_op[3]=0) accepted at edge t SHALL go IDLE->EXEC; in EXEC: alu_a=a, alu_b=b, alu_op=op; the result is captured at the EXEC end; rsp_valid is high from t+2.
REQ-007 Single-op response SHALL be rsp_y={W'h0, alu_y}, rsp_flags={alu_c,alu_v,alu_n,alu_z}, rsp_err=0.
REQ-008 MUL SHALL initialise acc_hi=0, acc_lo=b, counter=0, and run exactly W iterations in MUL.
- Each iteration: alu_a=acc_hi, alu_b=(acc_lo[0] ? a : 0), alu_op=ALU_OP_ADD (3'b000).
- Then {acc_hi,acc_lo} <= {alu_c, alu_y, acc_lo[W-1:1]}.
REQ-009 After W iterations the FSM SHALL enter RESP; MUL rsp_valid is high from t+W+1 (t+9 for W=8).
REQ-010 MUL response SHALL be rsp_y={acc_hi,acc_lo}, C=0, V=0, N=rsp_y[2W-1], Z=(rsp_y==0), rsp_err=0.
REQ-011 Any cmd_op with bit3=1 other than 4'b1000 SHALL go IDLE->RESP with rsp_err=1, rsp_y=0, rsp_flags=0, rsp_valid from t+1.
REQ-012 In RESP, rsp_y/rsp_flags/rsp_err SHALL hold stable until the rsp_valid&&rsp_ready handshake, then return to IDLE; cmd_ready stays 0 until that IDLE cycle (no overlap).
REQ-013 In IDLE and RESP, alu_op SHALL be 3'b000 and alu_a/alu_b SHALL be 0.

Reset
REQ-014 On rst_n low, at any time including mid-MUL, the block SHALL force IDLE and set rsp_valid=0, rsp_y=0, rsp_flags=0, rsp_err=0, counter=0, accumulators=0, alu_* outputs=0; cmd_ready=1 after release.
REQ-015 An in-flight command SHALL be discarded on reset, with no response.

Configuration
REQ-016 With ALU_SEQ_MUL_EN defined, MUL SHALL behave per REQ-008..010.
REQ-017 Without ALU_SEQ_MUL_EN:
- 4'b1000 SHALL be illegal per REQ-011.
- MUL state, counter and acc_hi SHALL not be synthesised.

Structure
REQ-018 Package alu_seq_pkg SHALL hold: ALU opcode constant ALU_OP_ADD, cmd_op constant CMD_MUL=4'b1000, FSM state enum, flag bit indices.
REQ-019 The accumulator/shift register and counter SHALL be one sub-module, alu_seq_acc; the ALU itself is instantiated by the parent, not inside this block.

Verification
REQ-020 cmd_op=0 (ADD), a=8'h7F, b=8'h01, accepted at t -> rsp_valid at t+2, rsp_y=16'h0080, flags C=0,V=1,N=1,Z=0.
REQ-021 MUL a=8'hFF, b=8'hFF at t -> rsp_valid at t+9, rsp_y=16'hFE01, N=1, Z=0, C=V=0.
REQ-022 MUL a=8'h55, b=8'h00 -> rsp_y=16'h0000, Z=1; MUL a=8'h0C, b=8'h0A -> rsp_y=16'h0078.
REQ-023 cmd_op=4'hA -> rsp_valid at t+1, rsp_err=1, rsp_y=0; without ALU_SEQ_MUL_EN, 4'h8 gives the same response.
REQ-024 rsp_ready held low 3 cycles -> outputs stable, cmd_ready=0; handshake -> IDLE, cmd_ready=1 next cycle.
REQ-025 rst_n pulsed low at MUL iteration 4 -> rsp_valid stays 0, cmd_ready=1 after release, next ADD completes correctly.
